kaipokrandt_mem_ctrl: RTL

//  Sequencer/arbiter for the memory path: drives MAR/MDR/memory control strobes and

---
 rtl/kaipokrandt_mem_ctrl_pkg.sv | 37 +++
 rtl/kaipokrandt_rr_arb2.sv | 22 ++
 rtl/kaipokrandt_mem_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/kaipokrandt_mem_ctrl_pkg.sv
// Shared types and constants for the memory-path sequencer/arbiter.
package kaipokrandt_mem_ctrl_pkg;

  // Requester indices on the shared MDR/memory port.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_EXEC  = 1'b1;

  // Transaction phases.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WAIT  = 3'd3,
    S_LATCH = 3'd4,
    S_DRIVE = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // All registered strobes, grouped so they can be decoded and flopped together.
  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       mar_load;
    logic       mdr_load_bus;
    logic       mdr_load_mem;
    logic       mdr_enable_bus;
    logic       mem_en;
    logic       mem_we;
  } strobes_t;

  // One-hot select of a requester.
  function automatic logic [1:0] onehot2(input logic sel);
    return (sel == REQ_EXEC) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/kaipokrandt_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright; on a tie the
// requester that was not granted last time wins.
module kaipokrandt_rr_arb2
  import kaipokrandt_mem_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       sel_o,
  output logic       valid_o
);

  // Pick the winner combinationally; the caller latches it on grant.
  always_comb begin
    valid_o = |req_i;
    if (&req_i) begin
      sel_o = ~last_i;
    end else begin
      sel_o = req_i[REQ_EXEC] ? REQ_EXEC : REQ_FETCH;
    end
  end

endmodule

// File: rtl/kaipokrandt_mem_ctrl.sv
// Memory-path sequencer: arbitrates fetch/execute requesters onto the single
// MAR/MDR/memory port and runs each access as a fixed multi-cycle transaction.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   S_IDLE  | no transaction; arbitrate any pending request
//   S_ADDR  | granted requester drives address, MAR loads
//   S_DATA  | write only: granted requester drives data, MDR loads
//   S_WAIT  | memory enabled for MEM_LAT cycles
//   S_LATCH | read only: MDR captures memory output
//   S_DRIVE | read only: MDR drives bus, done pulses
//   S_DONE  | write only: done pulses
//
// Strobes are decoded from the next state and flopped, so every output is a
// clean register that lines up with the state it belongs to.
module kaipokrandt_mem_ctrl
  import kaipokrandt_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] we,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       mar_load,
  output logic       mdr_load_bus,
  output logic       mdr_load_mem,
  output logic       mdr_enable_bus,
  output logic       mem_en,
  output logic       mem_we
);

  localparam int unsigned      CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             wr_q, wr_d;
  logic             last_q, last_d;
  strobes_t         out_q, out_d;
  logic             arb_sel, arb_valid;

  kaipokrandt_rr_arb2 u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .sel_o   (arb_sel),
    .valid_o (arb_valid)
  );

  // State, counter, latched transaction attributes and strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      last_q  <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic; requester and direction are frozen at grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_d = S_ADDR;
          sel_d   = arb_sel;
          wr_d    = we[arb_sel];
          last_d  = arb_sel;
        end
      end
      S_ADDR:  state_d = wr_q ? S_DATA : S_WAIT;
      S_DATA:  state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = wr_q ? S_DONE : S_LATCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: state_d = S_DRIVE;
      S_DRIVE: state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode from the next state, registered above.
  always_comb begin
    out_d      = '0;
    out_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_ADDR: begin
        out_d.gnt      = onehot2(sel_d);
        out_d.mar_load = 1'b1;
      end
      S_DATA: begin
        out_d.gnt          = onehot2(sel_d);
        out_d.mdr_load_bus = 1'b1;
      end
      S_WAIT: begin
        out_d.mem_en = 1'b1;
        out_d.mem_we = wr_d;
      end
      S_LATCH: out_d.mdr_load_mem = 1'b1;
      S_DRIVE: begin
        out_d.mdr_enable_bus = 1'b1;
        out_d.done           = onehot2(sel_d);
      end
      S_DONE:  out_d.done = onehot2(sel_d);
      default: ;
    endcase
  end

  assign gnt            = out_q.gnt;
  assign done           = out_q.done;
  assign busy           = out_q.busy;
  assign mar_load       = out_q.mar_load;
  assign mdr_load_bus   = out_q.mdr_load_bus;
  assign mdr_load_mem   = out_q.mdr_load_mem;
  assign mdr_enable_bus = out_q.mdr_enable_bus;
  assign mem_en         = out_q.mem_en;
  assign mem_we         = out_q.mem_we;

endmodule
